// File: rtl/dds_phase_gen.sv
// dds_phase_gen -- dual-channel DDS phase generator.
// A 32-bit phase accumulator drives the channel-A ROM address directly, and
// channel B through a 14-bit phase offset. New tuning words are staged in
// pending registers and applied only at an accumulator wrap, so the output
// phase never jumps.
// Optional feature: define DDS_SWEEP_EN to ramp the active tuning word toward
// the pending one by sweep_step per wrap instead of jumping to it.
module dds_phase_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ftw_in,
   input  logic [13:0] poff_b,
   input  logic        ftw_valid,
`ifdef DDS_SWEEP_EN
   input  logic [31:0] sweep_step,
`endif
   output logic        ftw_ready,
   output logic [13:0] addr_a,
   output logic [13:0] addr_b,
   output logic        wrap
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PEND = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_acc;
   logic [31:0] r_ftw_act;
   logic [31:0] r_ftw_pend;
   logic [13:0] r_poff_act;
   logic [13:0] r_poff_pend;
   logic [13:0] r_addr_a;
   logic [13:0] r_addr_b;
   logic        r_wrap;

   logic [32:0] w_sum;
   logic [31:0] w_acc_nxt;
   logic        w_carry;
   logic        w_accept;
   logic        w_step;      // active registers load on this edge
   logic        w_done;      // pending word fully applied on this edge
   logic [31:0] w_ftw_tgt;   // value ftw_act takes when w_step is set
   logic [31:0] w_ftw_nxt;
   logic [13:0] w_poff_nxt;

   // Accumulator sum with carry-out; the carry is the wrap event
   always_comb begin
      w_sum     = {1'b0, r_acc} + {1'b0, r_ftw_act};
      w_acc_nxt = w_sum[31:0];
      w_carry   = w_sum[32];
      w_accept  = (r_state == S_IDLE) && ftw_valid;
   end

`ifdef DDS_SWEEP_EN
   logic        w_direct;
   logic [31:0] w_diff;

   // Sweep: step ftw_act toward the target at each wrap, clamped at the target
   always_comb begin
      w_direct  = (r_ftw_act == 32'd0) || (sweep_step == 32'd0);
      w_step    = (r_state == S_PEND) && (w_carry || w_direct);
      w_diff    = 32'd0;
      w_ftw_tgt = r_ftw_pend;
      if (!w_direct) begin
         if (r_ftw_pend >= r_ftw_act) begin
            w_diff    = r_ftw_pend - r_ftw_act;
            w_ftw_tgt = (w_diff <= sweep_step) ? r_ftw_pend : (r_ftw_act + sweep_step);
         end else begin
            w_diff    = r_ftw_act - r_ftw_pend;
            w_ftw_tgt = (w_diff <= sweep_step) ? r_ftw_pend : (r_ftw_act - sweep_step);
         end
      end
      w_done    = w_step && (w_ftw_tgt == r_ftw_pend);
   end
`else
   // Direct apply: at a wrap, or at once when a zero FTW can never wrap
   always_comb begin
      w_step    = (r_state == S_PEND) && (w_carry || (r_ftw_act == 32'd0));
      w_ftw_tgt = r_ftw_pend;
      w_done    = w_step;
   end
`endif

   // Values the active registers take on this edge; addr_b uses the new
   // offset so it is consistent with addr_a from the apply edge onward
   always_comb begin
      w_ftw_nxt  = w_step ? w_ftw_tgt   : r_ftw_act;
      w_poff_nxt = w_step ? r_poff_pend : r_poff_act;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_PEND;
         S_PEND:  if (w_done)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ftw_ready = (r_state == S_IDLE);
   end

   // Datapath: accumulator, registered addresses, wrap pulse, FTW staging
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= 32'd0;
         r_ftw_act   <= 32'd0;
         r_ftw_pend  <= 32'd0;
         r_poff_act  <= 14'd0;
         r_poff_pend <= 14'd0;
         r_addr_a    <= 14'd0;
         r_addr_b    <= 14'd0;
         r_wrap      <= 1'b0;
      end else begin
         r_acc      <= w_acc_nxt;
         r_addr_a   <= w_acc_nxt[31:18];
         r_addr_b   <= w_acc_nxt[31:18] + w_poff_nxt;
         r_wrap     <= w_carry;
         r_ftw_act  <= w_ftw_nxt;
         r_poff_act <= w_poff_nxt;
         if (w_accept) begin
            r_ftw_pend  <= ftw_in;
            r_poff_pend <= poff_b;
         end
      end
   end

   // Output drive
   always_comb begin
      addr_a = r_addr_a;
      addr_b = r_addr_b;
      wrap   = r_wrap;
   end

endmodule

// File: doc/dds_phase_gen.md
DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `rst`; reset SHALL be synchronous and active-high.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock, the same clock that drives the sine ROMs and DACs.
REQ-003 Port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 Port `ftw_in`, input, 32 bits: frequency tuning word offered for loading.
REQ-005 Port `poff_b`, input, 14 bits: channel-B phase offset; sampled together with `ftw_in`.
REQ-006 Port `ftw_valid`, input, 1 bit: `ftw_in` and `poff_b` are valid.
REQ-007 Port `ftw_ready`, output, 1 bit: the block can accept a new word.
REQ-008 Port `addr_a`, output, 14 bits: channel-A sine ROM address.
REQ-009 Port `addr_b`, output, 14 bits: channel-B sine ROM address.
REQ-010 Port `wrap`, output, 1 bit: one-cycle pulse on each accumulator overflow.
REQ-011 Port `sweep_step`, input, 32 bits: FTW increment per wrap; this port SHALL exist only when DDS_SWEEP_EN is defined.

Function
REQ-012 Internal state: 32-bit accumulator `acc`, active FTW `ftw_act`, active offset `poff_act`, pending FTW `ftw_pend`, pending offset `poff_pend`.
REQ-013 Each cycle, `acc` SHALL update as acc_next = (acc + ftw_act) mod 2^32.
REQ-014 `addr_a` SHALL be registered as acc_next[31:18].
REQ-015 `addr_b` SHALL be registered as (acc_next[31:18] + poff_act) mod 2^14, updating on the same edge as `addr_a`.
REQ-016 `wrap` SHALL be registered high for exactly one cycle on each edge where acc + ftw_act carries out of bit 31.
REQ-017 Control FSM states: IDLE (`ftw_ready`=1) and PEND (`ftw_ready`=0).
REQ-018 Accept: `ftw_valid`=1 in IDLE SHALL capture `ftw_in` into `ftw_pend` and `poff_b` into `poff_pend`, and SHALL go to PEND.
REQ-019 Apply, for phase continuity: in PEND, on the edge that asserts `wrap`, the block SHALL load `ftw_act` and `poff_act` from the pending registers and return to IDLE.
- The new FTW first affects the accumulation on the following cycle.
- `acc` SHALL NOT be cleared.
REQ-020 If `ftw_act`=0 in PEND, the apply SHALL occur on the next edge without waiting for a wrap, since no wrap can ever occur.
REQ-021 Accept on the same edge as a wrap: the captured word SHALL wait for the next wrap.
REQ-022 `ftw_valid` asserted in PEND SHALL be ignored; the source holds the word until it sees `ftw_ready`.
REQ-023 Accepting FTW=0 is legal; after apply, `acc` and both addresses SHALL freeze.

Reset
REQ-024 On `rst`=1 at an edge, the following SHALL be set:
- `acc`, `ftw_act`, `ftw_pend`, `poff_act`, `poff_pend` = 0.
- `addr_a`, `addr_b` = 0.
- `wrap` = 0.
- FSM = IDLE, so `ftw_ready` = 1 on the first cycle after reset.
REQ-025 Reset in PEND SHALL discard the pending word.
REQ-026 `ftw_valid` SHALL be ignored while `rst`=1.

Configuration
REQ-027 Macro DDS_SWEEP_EN SHALL select how a pending FTW is applied.
REQ-028 Without DDS_SWEEP_EN: the apply SHALL behave per REQ-019/020.
REQ-029 With DDS_SWEEP_EN:
- In PEND, at each wrap, `ftw_act` SHALL move toward `ftw_pend` by `sweep_step`, clamped so it never overshoots `ftw_pend`.
- `poff_act` SHALL load at the first step.
- The FSM SHALL return to IDLE on the edge where `ftw_act` equals `ftw_pend`.
- `sweep_step`=0 or `ftw_act`=0 SHALL apply `ftw_pend` directly.

Verification
REQ-030 Start: reset, then `ftw_in`=0x0400_0000 with `ftw_valid` for 1 cycle.
- Apply occurs on the next edge.
- `addr_a` then steps 0x000, 0x100, 0x200, ...
- `wrap` pulses every 64 cycles.
REQ-031 Offset: as REQ-030 with `poff_b`=0x2000 -> `addr_b` = (`addr_a` + 0x2000) mod 2^14 on every cycle.
REQ-032 Retune: active 0x0400_0000, load 0x0800_0000 mid-period.
- `ftw_ready`=0 until the wrap edge.
- The step becomes 0x200 from the cycle after the wrap.
- There is no address jump.
REQ-033 Back-pressure: second `ftw_valid` (0x1234_5678) held during PEND -> not captured until `ftw_ready`=1, then accepted.
REQ-034 Reset mid-PEND: `rst` pulse -> all outputs 0, `ftw_ready`=1, old pending word never applied.
REQ-035 Sweep (DDS_SWEEP_EN): active 0x0400_0000, target 0x0440_0000, `sweep_step`=0x0010_0000.
- `ftw_act` takes the values 0x0410_0000, 0x0420_0000, 0x0430_0000, 0x0440_0000 at 4 successive wraps.
- IDLE is reached on the 4th wrap.
